// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults for the register file and its scoreboard.
//   RF_DATA_W / RF_ADDR_W : default register width / address width
//   rf_zero_addr          : address of the hardwired-zero register
package rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int unsigned rf_zero_addr = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits plus a registered count of set bits.
//   clk, rst          : clock, async active-high reset
//   wr_en/wr_addr     : two writeback ports, each clears busy[wr_addr]
//   rsv_en/rsv_addr   : decode reservation, sets busy[rsv_addr] (wins over a write)
//   busy              : busy vector, one bit per register
//   busy_cnt          : popcount(busy), maintained incrementally
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             wr_en,
  input  logic [2*ADDR_W-1:0]    wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(rf_zero_addr);

  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] wa0, wa1;
  logic              wv0, wv1, rv, inc, dec0, dec1;

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];

  always_comb begin
    wv0 = wr_en[0] && !(ZERO_REG != 0 && wa0 == ZADDR);
    wv1 = wr_en[1] && !(ZERO_REG != 0 && wa1 == ZADDR);
    rv  = rsv_en   && !(ZERO_REG != 0 && rsv_addr == ZADDR);

    busy_d = busy_q;
    if (wv0) busy_d[wa0] = 1'b0;
    if (wv1) busy_d[wa1] = 1'b0;
    if (rv)  busy_d[rsv_addr] = 1'b1;  // reserve applied last so it wins

    // Count only real transitions: a reserve on an already-busy register,
    // a write on a reserved-this-cycle register, or the second port of a
    // collision must not move the counter.
    inc  = rv && !busy_q[rsv_addr];
    dec0 = wv0 && busy_q[wa0] && !(rv && rsv_addr == wa0);
    dec1 = wv1 && busy_q[wa1] && !(rv && rsv_addr == wa1) && !(wv0 && wa0 == wa1);
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-write / NRD-read register file with optional write-to-read
// bypass and a busy scoreboard for decode stall decisions.
//   clk, rst          : clock, async active-high reset
//   rd_addr/rd_data   : packed read ports (combinational)
//   rd_busy           : addressed register still awaits its writeback
//   wr_en/wr_addr/wr_data : two write ports, port 1 wins on collision
//   rsv_en/rsv_addr   : reserve destination register (busy next cycle)
//   busy_cnt          : number of busy registers
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [1:0]            wr_en,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [ADDR_W:0]       busy_cnt
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(rf_zero_addr);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              wv0, wv1;

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];
  assign wd0 = wr_data[0 +: DATA_W];
  assign wd1 = wr_data[DATA_W +: DATA_W];
  assign wv0 = wr_en[0] && !(ZERO_REG != 0 && wa0 == ZADDR);
  assign wv1 = wr_en[1] && !(ZERO_REG != 0 && wa1 == ZADDR);

  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    regs_d = regs_q;
    if (wv0) regs_d[wa0] = wd0;
    if (wv1) regs_d[wa1] = wd1;  // port 1 last: wins a collision
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbsy, hit0, hit1;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      hit0 = (BYPASS != 0) && wv0 && (wa0 == ra);
      hit1 = (BYPASS != 0) && wv1 && (wa1 == ra);
      // Outputs are forced low during reset so a bypass of in-flight
      // write data cannot leak out while the array is being cleared.
      if (rst || (ZERO_REG != 0 && ra == ZADDR)) begin
        rdat = '0;
        rbsy = 1'b0;
      end else begin
        if (hit1)      rdat = wd1;
        else if (hit0) rdat = wd0;
        else           rdat = regs_q[ra];
        rbsy = busy[ra] && !(hit0 || hit1);
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
    assign rd_busy[k]                  = rbsy;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [5:0]  busy_cnt;
  // second instance: no zero register, no bypass, one read port (port 0 address)
  logic [31:0] rd_data1;
  logic [0:0]  rd_busy1;
  logic [5:0]  busy_cnt1;

  int vecs = 0;
  int errs = 0;

  // reference state, index 0 = default DUT, index 1 = ZERO_REG=0/BYPASS=0 DUT
  logic [31:0] m [2][32];
  bit          b [2][32];

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.NRD(1), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr[4:0]), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int d, input logic [4:0] a);
    bit on = (d == 0);  // instance 0 has both zero register and bypass
    if (on && a == 5'd0) return 32'h0;
    if (on && wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
    if (on && wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
    return m[d][a];
  endfunction

  function automatic logic exp_busy(input int d, input logic [4:0] a);
    bit on = (d == 0);
    if (on && a == 5'd0) return 1'b0;
    if (on && ((wr_en[1] && wr_addr[9:5] == a) || (wr_en[0] && wr_addr[4:0] == a))) return 1'b0;
    return b[d][a];
  endfunction

  function automatic logic [5:0] popc(input int d);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(b[d][i]);
    return 6'(n);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        m[d][i] = '0;
        b[d][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit zr = (d == 0);
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a = wr_addr[p*5 +: 5];
        if (wr_en[p] && !(zr && a == 5'd0)) begin
          m[d][a] = wr_data[p*32 +: 32];
          b[d][a] = 1'b0;
        end
      end
      if (rsv_en && !(zr && rsv_addr == 5'd0)) b[d][rsv_addr] = 1'b1;
    end
  endtask

  task automatic check_now();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a = rd_addr[k*5 +: 5];
      chk($sformatf("rd_data%0d a=%0d", k, a), rd_data[k*32 +: 32], exp_data(0, a));
      chk($sformatf("rd_busy%0d a=%0d", k, a), 32'(rd_busy[k]), 32'(exp_busy(0, a)));
    end
    chk($sformatf("u1 rd_data a=%0d", rd_addr[4:0]), rd_data1, exp_data(1, rd_addr[4:0]));
    chk($sformatf("u1 rd_busy a=%0d", rd_addr[4:0]), 32'(rd_busy1[0]), 32'(exp_busy(1, rd_addr[4:0])));
    chk("busy_cnt", 32'(busy_cnt), 32'(popc(0)));
    chk("u1 busy_cnt", 32'(busy_cnt1), 32'(popc(1)));
  endtask

  task automatic fin();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_now();
    fin();
  endtask

  task automatic idle();
    wr_en = 2'b00; rsv_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0; idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cyc();  // reset state: everything zero

    // scoreboard: reserve r4, write r4, reserve+write r4
    rd_addr = {5'd0, 5'd4};
    rsv(5'd4); cyc(); idle();
    @(negedge clk); check_now();
    chk("r4 busy after reserve", 32'(rd_busy[0]), 32'd1);
    chk("cnt after reserve r4", 32'(busy_cnt), 32'd1);
    fin();
    wr(0, 5'd4, 32'hA5A5_0004);
    @(negedge clk); check_now();
    chk("r4 busy same-cycle write", 32'(rd_busy[0]), 32'd0);
    fin(); idle();
    @(negedge clk); check_now();
    chk("cnt after write r4", 32'(busy_cnt), 32'd0);
    fin();
    rsv(5'd4); wr(1, 5'd4, 32'h0BAD_F00D); cyc(); idle();
    @(negedge clk); check_now();
    chk("r4 stays busy", 32'(rd_busy[0]), 32'd1);
    chk("r4 holds data", rd_data[31:0], 32'h0BAD_F00D);
    fin();

    // bypass r3
    rd_addr = {5'd4, 5'd3};
    wr(0, 5'd3, 32'h1234_5678);
    @(negedge clk); check_now();
    chk("bypass r3", rd_data[31:0], 32'h1234_5678);
    chk("no-bypass r3 old", rd_data1, 32'h0);
    fin(); idle();
    @(negedge clk); check_now();
    chk("no-bypass r3 next", rd_data1, 32'h1234_5678);
    fin();

    // write collision on busy r9
    rd_addr = {5'd9, 5'd9};
    rsv(5'd9); cyc(); idle();
    wr(0, 5'd9, 32'h1111); wr(1, 5'd9, 32'h2222);
    @(negedge clk); check_now();
    chk("collision bypass", rd_data[31:0], 32'h2222);
    fin(); idle();
    cyc();

    // zero register
    rd_addr = {5'd0, 5'd0};
    wr(0, 5'd0, 32'hFFFF_FFFF); rsv(5'd0); cyc(); idle();
    cyc();

    // fill r1..r31, then clear with dual-port writes
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i - 1)};
      rsv(5'(i)); cyc();
    end
    idle();
    @(negedge clk); check_now();
    chk("fill busy_cnt", 32'(busy_cnt), 32'd31);
    fin();
    for (int j = 0; j < 16; j++) begin
      wr(0, 5'(2*j + 1), $urandom); wr(1, 5'((2*j + 2) % 32), $urandom);
      rd_addr = {5'(2*j + 1), 5'(2*j + 2)};
      cyc();
    end
    idle();
    @(negedge clk); check_now();
    chk("clear busy_cnt", 32'(busy_cnt), 32'd0);
    fin();

    // randomized traffic, addresses sometimes narrowed to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] mask = ($urandom_range(0, 1) != 0) ? 5'h07 : 5'h1F;
      rd_addr  = {5'($urandom) & mask, 5'($urandom) & mask};
      wr_en    = 2'($urandom);
      wr_addr  = {5'($urandom) & mask, 5'($urandom) & mask};
      wr_data  = {$urandom, $urandom};
      rsv_en   = 1'($urandom);
      rsv_addr = 5'($urandom) & mask;
      cyc();
    end
    idle();

    // async reset mid-cycle with a write and a reserve in flight
    wr(0, 5'd5, 32'hDEAD_BEEF); rsv(5'd7); cyc();
    rd_addr = {5'd7, 5'd5};
    wr(0, 5'd5, 32'hCAFE_CAFE); rsv(5'd7);
    #3 rst = 1'b1;
    #1;
    chk("rst rd_data0", rd_data[31:0], 32'h0);
    chk("rst rd_data1", rd_data[63:32], 32'h0);
    chk("rst rd_busy", 32'(rd_busy), 32'd0);
    chk("rst busy_cnt", 32'(busy_cnt), 32'd0);
    chk("rst u1 rd_data", rd_data1, 32'h0);
    chk("rst u1 busy_cnt", 32'(busy_cnt1), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk); rst = 1'b0; idle();
    @(posedge clk); #1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port integer register file with two write ports, optional write-to-read bypass and a per-register busy scoreboard. Sits in the decode/writeback path of the pipelined cores. Decode reads operands and reserves the destination. Writeback ports retire results and clear the reservation. `rd_busy` gives decode a ready/stall indication per operand.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: address width; the file holds NREGS = 2**ADDR_W registers.
- `NRD`, default 2: number of read ports (1..4).
- `ZERO_REG`, default 1: when 1, register 0 reads as zero, ignores writes and can never be busy.
- `BYPASS`, default 1: when 1, same-cycle write data is forwarded to matching reads.

Ports (one clock, `clk`; reset `rst` is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `rd_addr` in NRD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- `rd_data` out NRD*DATA_W: packed read data.
- `rd_busy` out NRD: 1 when the addressed register still awaits a write.
- `wr_en` in 2: write enables, ports 0 and 1.
- `wr_addr` in 2*ADDR_W: packed write addresses.
- `wr_data` in 2*DATA_W: packed write data.
- `rsv_en` in 1: reserve (set busy) request.
- `rsv_addr` in ADDR_W: register to reserve.
- `busy_cnt` out ADDR_W+1: number of registers currently marked busy.

## Operation
- Storage: NREGS x DATA_W flops plus a busy vector of NREGS bits.
- Write: on the rising edge, each enabled port writes `wr_data` to `wr_addr`.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Both ports enabled on the same address: port 1 wins, for both data and forwarding.
- Scoreboard:
  - A write clears busy[wr_addr]. A write to a non-busy register is legal and leaves it clear.
  - `rsv_en` sets busy[rsv_addr]. With ZERO_REG=1, reserving address 0 is ignored.
  - Reserve and write to the same address in the same cycle: reserve wins, so busy ends at 1 and the data is still written.
- Read, combinational, per port k, priority high to low:
  1. ZERO_REG and addr 0 -> data 0, busy 0.
  2. BYPASS and `wr_en[1]` to a matching address -> `wr_data[1]`.
  3. BYPASS and `wr_en[0]` to a matching address -> `wr_data[0]`.
  4. Otherwise the stored value.
- `rd_busy[k]`: busy[addr] AND NOT (BYPASS and a same-cycle write to addr). The same-cycle reserve is not reflected until the next cycle. With BYPASS=0, `rd_busy` reflects the stored busy bit only.
- `busy_cnt` is a registered counter updated each edge by (+1 if a reserve newly sets a bit) (-1 per write that clears a set bit, counting a port-0/port-1 collision once). It always equals popcount(busy) after the edge.

## Timing
- Reset (async assert, sync release): all registers = 0, busy = 0, `busy_cnt` = 0. `rd_data` = 0 and `rd_busy` = 0 for every address while in reset.
- Reset asserted mid-operation discards in-flight writes and reservations in that cycle.
- Write-to-read latency:
  - BYPASS=1: 0 cycles, data visible the same cycle.
  - BYPASS=0: 1 cycle.
- Reserve-to-busy latency: 1 cycle.
- No handshake backpressure: all requests are accepted every cycle.

## Structure
- Shared package `rf_pkg`: the `ADDR_W`/`DATA_W` defaults and a `rf_zero_addr` constant.
- Sub-module `rf_scoreboard`: owns the busy vector and `busy_cnt`. Inputs: write/reserve requests. Outputs: busy vector and count.
- Data array and read muxes stay in `reg_file_sb`, generated per read port.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, reserve r7, assert `rst` asynchronously -> all reads 0, `busy_cnt` = 0, before the next clock edge.
- **Bypass:** `wr_en[0]`, r3 <- 0x12345678 while `rd_addr` port 0 = 3 -> same-cycle `rd_data` = 0x12345678. With BYPASS=0 the old value shows, and the new value appears the next cycle.
- **Write collision:** both ports write r9, port0 = 0x1111, port1 = 0x2222 -> bypassed and stored value 0x2222. `busy_cnt` decrements by exactly 1 if r9 was busy.
- **Scoreboard:**
  - Reserve r4 -> next cycle `rd_busy` = 1, `busy_cnt` = 1.
  - Write r4 -> same-cycle `rd_busy` = 0, next cycle `busy_cnt` = 0.
  - Reserve and write r4 together -> r4 stays busy and holds the written data.
- **Zero register:** write 0xFFFFFFFF to r0 and reserve r0 -> reads 0, `rd_busy` 0, `busy_cnt` unchanged. With ZERO_REG=0, r0 behaves like any other register.
- **Fill:** reserve r1..r31 on consecutive cycles -> `busy_cnt` = 31. Then clear all with dual-port writes -> `busy_cnt` reaches 0 after 16 cycles.
